// File: rtl/multi_sum_pkg.sv
// multi_sum_pkg
// Shared helpers for the N-channel FIFO adder.
//   full_width(width, n_inputs) : bits needed to hold the sum of n_inputs
//                                 unsigned width-bit operands without overflow
//   sat_or_wrap(value, sum_width): reduces a full-precision sum to sum_width
//                                 bits, either wrapping or saturating
//   sat_default                 : 1 when built with MULTI_SUM_SATURATE_EN
// Configuration macro: MULTI_SUM_SATURATE_EN (saturate instead of wrap when
// the result port is narrower than the full-precision sum).
package multi_sum_pkg;

`ifdef MULTI_SUM_SATURATE_EN
    localparam bit sat_default = 1'b1;
`else
    localparam bit sat_default = 1'b0;
`endif

    function automatic int full_width(input int width, input int n_inputs);
        return width + $clog2(n_inputs);
    endfunction

    // Values up to 64 bits are handled; the caller casts the result down to
    // sum_width. A value that already fits is returned unchanged in either
    // mode, so saturation has no effect when the port is full precision.
    function automatic logic [63:0] sat_or_wrap(input logic [63:0] value,
                                                input int          sum_width);
        logic [63:0] max_val;
        if (sum_width >= 64) begin
            return value;
        end
        max_val = (64'd1 << sum_width) - 64'd1;
        if (sat_default && (value > max_val)) begin
            return max_val;
        end
        return value & max_val;
    endfunction

endpackage

// File: rtl/double_buffer_from_dally_harting.sv
// double_buffer_from_dally_harting
// Two-entry valid/ready buffer. up_ready comes only from registered state,
// which breaks the combinational ready path, while two slots still allow
// one transfer per cycle when the downstream keeps accepting.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   up_valid, up_ready, up_data    upstream handshake
//   down_valid, down_ready, down_data  downstream handshake
module double_buffer_from_dally_harting #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [width-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [width-1:0] down_data
);

    logic [width-1:0] slot [2];
    logic             head;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign up_ready   = (count != 2'd2);
    assign down_valid = (count != 2'd0);
    assign down_data  = slot[head];
    assign push       = up_valid & up_ready;
    assign pop        = down_valid & down_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (pop) head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Tail is head when empty and the other slot when one entry is held.
    always_ff @(posedge clk) begin
        if (push) slot[head ^ count[0]] <= up_data;
    end

endmodule

// File: rtl/flip_flop_fifo_with_counter.sv
// flip_flop_fifo_with_counter
// Register-based FIFO with an occupancy counter. No bypass: an element
// pushed into an empty FIFO becomes visible on the following cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write strobe and data (ignored while full)
//   pop, pop_data     read strobe (ignored while empty), head element
//   empty, full       registered occupancy flags
module flip_flop_fifo_with_counter #(
    parameter int width = 8,
    parameter int depth = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int cnt_w = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly because depth need not be a power of two.
    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == cnt_w'(depth));
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the counter alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/multi_sum_join_adder.sv
// multi_sum_join_adder
// Combinational join and reduction: pops every channel together only when
// all channels hold data and the output buffer has room, and adds the head
// elements at full precision before wrapping or saturating to sum_width.
// Ports:
//   fifo_empty    per-channel empty flags
//   fifo_data     per-channel head elements, channel i at [i*width +: width]
//   buf_up_ready  output buffer can accept a sum
//   pop_all       pop strobe shared by all channel FIFOs (also buffer valid)
//   sum           reduced sum
module multi_sum_join_adder #(
    parameter int n_inputs  = 4,
    parameter int width     = 8,
    parameter int sum_width = 10
) (
    input  logic [n_inputs-1:0]       fifo_empty,
    input  logic [n_inputs*width-1:0] fifo_data,
    input  logic                      buf_up_ready,
    output logic                      pop_all,
    output logic [sum_width-1:0]      sum
);

    import multi_sum_pkg::*;

    localparam int full_w = full_width(width, n_inputs);

    logic              all_avail;
    logic [full_w-1:0] acc;

    assign all_avail = ~|fifo_empty;
    assign pop_all   = all_avail & buf_up_ready;

    // Zero-extended operands cannot overflow full_w bits.
    always_comb begin
        acc = '0;
        for (int i = 0; i < n_inputs; i++) begin
            acc = acc + full_w'(fifo_data[i*width +: width]);
        end
    end

    assign sum = sum_width'(sat_or_wrap(64'(acc), sum_width));

endmodule

// File: rtl/multi_sum_using_fifos_and_double_buffer.sv
// multi_sum_using_fifos_and_double_buffer
// N-channel element-wise adder. Each channel is buffered in its own FIFO so
// producers may be skewed; one element from every channel is summed per pop
// and the result leaves through a two-entry double buffer.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid, in_ready, in_data  per-channel input streams
//   sum_valid, sum_ready, sum_data  result stream
// Configuration macro: MULTI_SUM_SATURATE_EN (saturating narrow results).
module multi_sum_using_fifos_and_double_buffer
    import multi_sum_pkg::*;
#(
    parameter int n_inputs  = 4,
    parameter int width     = 8,
    parameter int depth     = 10,
    parameter int sum_width = full_width(width, n_inputs)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_inputs-1:0]       in_valid,
    output logic [n_inputs-1:0]       in_ready,
    input  logic [n_inputs*width-1:0] in_data,
    output logic                      sum_valid,
    input  logic                      sum_ready,
    output logic [sum_width-1:0]      sum_data
);

    logic [n_inputs-1:0]       fifo_empty;
    logic [n_inputs-1:0]       fifo_full;
    logic [n_inputs-1:0]       push;
    logic [n_inputs*width-1:0] fifo_data;
    logic                      pop_all;
    logic                      buf_up_ready;
    logic [sum_width-1:0]      sum;

    // Ready depends only on fullness, so a full channel never accepts even
    // when a pop happens in the same cycle.
    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;

    for (genvar i = 0; i < n_inputs; i++) begin : g_chan
        flip_flop_fifo_with_counter #(
            .width(width),
            .depth(depth)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[i]),
            .push_data(in_data[i*width +: width]),
            .pop      (pop_all),
            .pop_data (fifo_data[i*width +: width]),
            .empty    (fifo_empty[i]),
            .full     (fifo_full[i])
        );
    end

    multi_sum_join_adder #(
        .n_inputs (n_inputs),
        .width    (width),
        .sum_width(sum_width)
    ) u_join (
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .buf_up_ready(buf_up_ready),
        .pop_all     (pop_all),
        .sum         (sum)
    );

    // pop_all already includes buf_up_ready, so it doubles as up_valid.
    double_buffer_from_dally_harting #(
        .width(sum_width)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (pop_all),
        .up_ready  (buf_up_ready),
        .up_data   (sum),
        .down_valid(sum_valid),
        .down_ready(sum_ready),
        .down_data (sum_data)
    );

endmodule

// File: tb/tb_multi_sum_using_fifos_and_double_buffer.sv
// tb_multi_sum_using_fifos_and_double_buffer
// Directed bench for the N-channel FIFO adder. A second instance with an
// 8-bit result port shares the inputs to cover the narrow wrap/saturate path.
module tb_multi_sum_using_fifos_and_double_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  in_ready8;
    logic [31:0] in_data;
    logic        sum_valid;
    logic        sum_valid8;
    logic        sum_ready;
    logic [9:0]  sum_data;
    logic [7:0]  sum_data8;

    int errors = 0;
    int checks = 0;

`ifdef MULTI_SUM_SATURATE_EN
    localparam int exp8_1020 = 255;
    localparam int exp8_510  = 255;
`else
    localparam int exp8_1020 = 252;
    localparam int exp8_510  = 254;
`endif

    always #5 clk = ~clk;

    multi_sum_using_fifos_and_double_buffer #(
        .n_inputs(4), .width(8), .depth(10), .sum_width(10)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sum_data(sum_data)
    );

    multi_sum_using_fifos_and_double_buffer #(
        .n_inputs(4), .width(8), .depth(10), .sum_width(8)
    ) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .sum_valid(sum_valid8), .sum_ready(sum_ready),
        .sum_data(sum_data8)
    );

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = '0; in_data = '0; sum_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_sum_valid: got %b expected 0", sum_valid);
        end
        checks++;
        if (in_ready !== 4'hF) begin
            errors++; $display("[TB] FAIL reset_in_ready: got %h expected f", in_ready);
        end
        step();
    endtask

    // One beat on all channels, sum visible two cycles after the push edge.
    task automatic test_basic_sum();
        sum_ready = 1'b1;
        in_valid  = 4'hF;
        in_data   = {8'd4, 8'd3, 8'd2, 8'd1};
        @(negedge clk);
        checks++;
        if (in_ready !== 4'hF) begin
            errors++; $display("[TB] FAIL basic_in_ready: got %h expected f", in_ready);
        end
        step();
        in_valid = '0;
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_early_valid: got %b expected 0", sum_valid);
        end
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b1 || sum_data !== 10'd10) begin
            errors++; $display("[TB] FAIL basic_sum: got valid=%b data=%0d expected valid=1 data=10",
                               sum_valid, sum_data);
        end
        checks++;
        if (in_ready !== 4'hF) begin
            errors++; $display("[TB] FAIL basic_in_ready_after: got %h expected f", in_ready);
        end
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_single_beat: got %b expected 0", sum_valid);
        end
        step();
    endtask

    // Channels 0-2 at edge 0, channel 3 at edge 6: result only in cycle 8.
    task automatic test_skew();
        sum_ready = 1'b1;
        in_valid  = 4'b0111;
        in_data   = {8'd0, 8'd5, 8'd5, 8'd5};
        step();
        in_valid = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (sum_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL skew_wait_%0d: got %b expected 0", k, sum_valid);
            end
            step();
        end
        in_valid = 4'b1000;
        in_data  = {8'd7, 8'd0, 8'd0, 8'd0};
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL skew_cycle6: got %b expected 0", sum_valid);
        end
        step();
        in_valid = '0;
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL skew_cycle7: got %b expected 0", sum_valid);
        end
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b1 || sum_data !== 10'd22) begin
            errors++; $display("[TB] FAIL skew_sum: got valid=%b data=%0d expected valid=1 data=22",
                               sum_valid, sum_data);
        end
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL skew_single_beat: got %b expected 0", sum_valid);
        end
        step();
    endtask

    // 255*4 = 1020 at full precision; 255+255 = 510 on both widths.
    task automatic test_widths();
        sum_ready = 1'b1;
        in_valid  = 4'hF;
        in_data   = {8'd255, 8'd255, 8'd255, 8'd255};
        step();
        in_data   = {8'd0, 8'd0, 8'd255, 8'd255};
        step();
        in_valid  = '0;
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b1 || sum_data !== 10'd1020) begin
            errors++; $display("[TB] FAIL full_precision_1020: got valid=%b data=%0d expected 1020",
                               sum_valid, sum_data);
        end
        checks++;
        if (sum_valid8 !== 1'b1 || sum_data8 !== 8'(exp8_1020)) begin
            errors++; $display("[TB] FAIL narrow_1020: got valid=%b data=%0d expected %0d",
                               sum_valid8, sum_data8, exp8_1020);
        end
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b1 || sum_data !== 10'd510) begin
            errors++; $display("[TB] FAIL full_precision_510: got valid=%b data=%0d expected 510",
                               sum_valid, sum_data);
        end
        checks++;
        if (sum_valid8 !== 1'b1 || sum_data8 !== 8'(exp8_510)) begin
            errors++; $display("[TB] FAIL narrow_510: got valid=%b data=%0d expected %0d",
                               sum_valid8, sum_data8, exp8_510);
        end
        step(); step();
    endtask

    // Beat k carries k+i on channel i, so its sum is 4k+6.
    task automatic test_backpressure();
        int idx;
        sum_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            in_valid = 4'hF;
            in_data  = {8'(k + 3), 8'(k + 2), 8'(k + 1), 8'(k)};
            @(negedge clk);
            checks++;
            if (in_ready !== 4'hF) begin
                errors++; $display("[TB] FAIL bp_fill_ready_%0d: got %h expected f", k, in_ready);
            end
            step();
        end
        // Offered beats that must be refused while everything is full.
        in_data = {8'd200, 8'd200, 8'd200, 8'd200};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 4'h0) begin
                errors++; $display("[TB] FAIL bp_full_ready_%0d: got %h expected 0", k, in_ready);
            end
            checks++;
            if (sum_valid !== 1'b1 || sum_data !== 10'd6) begin
                errors++; $display("[TB] FAIL bp_hold: got valid=%b data=%0d expected valid=1 data=6",
                                   sum_valid, sum_data);
            end
            step();
        end
        in_valid  = '0;
        sum_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (sum_valid === 1'b1) begin
                checks++;
                if (idx >= 12) begin
                    errors++; $display("[TB] FAIL bp_extra_result: got %0d expected none", sum_data);
                end else if (sum_data !== 10'(4 * idx + 6)) begin
                    errors++; $display("[TB] FAIL bp_order_%0d: got %0d expected %0d",
                                       idx, sum_data, 4 * idx + 6);
                end
                idx++;
            end
            step();
        end
        checks++;
        if (idx != 12) begin
            errors++; $display("[TB] FAIL bp_result_count: got %0d expected 12", idx);
        end
    endtask

    // Reset with 2 sums buffered and 3 entries per FIFO; only the
    // post-reset beat (10+20+30+40 = 100) may appear afterwards.
    task automatic test_mid_reset();
        int seen;
        sum_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 4'hF;
            in_data  = {8'(k + 1), 8'(k + 1), 8'(k + 1), 8'(k + 1)};
            step();
        end
        in_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sum_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", sum_valid);
        end
        checks++;
        if (in_ready !== 4'hF) begin
            errors++; $display("[TB] FAIL mid_reset_ready: got %h expected f", in_ready);
        end
        step();
        sum_ready = 1'b1;
        in_valid  = 4'hF;
        in_data   = {8'd40, 8'd30, 8'd20, 8'd10};
        step();
        in_valid = '0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sum_valid === 1'b1) begin
                checks++;
                if (sum_data !== 10'd100) begin
                    errors++; $display("[TB] FAIL mid_reset_data: got %0d expected 100", sum_data);
                end
                seen++;
            end
            step();
        end
        checks++;
        if (seen != 1) begin
            errors++; $display("[TB] FAIL mid_reset_count: got %0d expected 1", seen);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_data = '0; sum_ready = 1'b0;
        $display("[TB] starting");
        test_reset();
        test_basic_sum();
        test_skew();
        test_widths();
        test_backpressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
